// File: rtl/text_overlay_gen.sv
// rtl/text_overlay_gen.sv - "ISA" text overlay: pixel to font ROM address, glyph bit select, colour cycling
// Define TEXT_BLINK_EN to add frame-driven text blinking.
module text_overlay_gen #(
  parameter logic [9:0]  TEXT_X0      = 10'd256,
  parameter logic [9:0]  TEXT_Y0      = 10'd224,
  parameter logic [7:0]  COLOR_FRAMES = 8'd60,
  parameter logic [7:0]  BLINK_FRAMES = 8'd30,
  parameter logic [11:0] BG_COLOR     = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        pixel_tick,
  output logic [5:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic        text_on,
  output logic [11:0] rgb
);

  typedef enum logic [1:0] {RED, GREEN, BLUE} color_t;

  color_t      state, state_next;
  logic [7:0]  frame_cnt;
  logic [11:0] fg;
  logic [9:0]  dx, dy;
  logic [1:0]  char_code;
  logic        in_region;
  logic [2:0]  col_d1;
  logic        in_region_d1, video_on_d1;
  logic        frame_pulse, color_wrap, show;
  logic        glyph_bit, text_on_next;
  logic [11:0] rgb_next;

  assign dx        = pixel_x - TEXT_X0;
  assign dy        = pixel_y - TEXT_Y0;
  assign in_region = (pixel_x >= TEXT_X0) && (dx < 10'd24) &&
                     (pixel_y >= TEXT_Y0) && (dy < 10'd16);
  // Glyph 0 is blank, so the string's three cells map to codes 1..3.
  assign char_code = dx[4:3] + 2'd1;
  assign rom_addr  = in_region ? {char_code, dy[3:0]} : 6'h00;

  assign frame_pulse = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);
  assign color_wrap  = frame_pulse && (frame_cnt == COLOR_FRAMES - 8'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      col_d1       <= 3'd0;
      in_region_d1 <= 1'b0;
      video_on_d1  <= 1'b0;
    end else begin
      col_d1       <= dx[2:0];
      in_region_d1 <= in_region;
      video_on_d1  <= video_on;
    end
  end

  // Stage-1 context lines up with the ROM's one-clock registered read.
  assign glyph_bit    = rom_data[3'd7 - col_d1];
  assign text_on_next = video_on_d1 && in_region_d1 && glyph_bit && show;
  assign rgb_next     = !video_on_d1 ? 12'h000 : (text_on_next ? fg : BG_COLOR);

  always_ff @(posedge clk) begin
    if (reset) begin
      text_on <= 1'b0;
      rgb     <= 12'h000;
    end else begin
      text_on <= text_on_next;
      rgb     <= rgb_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= 8'd0;
      state     <= RED;
    end else begin
      state <= state_next;
      if (frame_pulse)
        frame_cnt <= color_wrap ? 8'd0 : frame_cnt + 8'd1;
    end
  end

  always_comb begin
    state_next = state;
    fg         = 12'hF00;
    case (state)
      RED: begin
        fg = 12'hF00;
        if (color_wrap) state_next = GREEN;
      end
      GREEN: begin
        fg = 12'h0F0;
        if (color_wrap) state_next = BLUE;
      end
      BLUE: begin
        fg = 12'h00F;
        if (color_wrap) state_next = RED;
      end
      default: state_next = RED;
    endcase
  end

`ifdef TEXT_BLINK_EN
  logic [7:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= 8'd0;
      show      <= 1'b1;
    end else if (frame_pulse) begin
      if (blink_cnt == BLINK_FRAMES - 8'd1) begin
        blink_cnt <= 8'd0;
        show      <= ~show;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end
`else
  logic blink_frames_unused;

  assign blink_frames_unused = ^BLINK_FRAMES;
  assign show = 1'b1;
`endif

endmodule

// File: tb/tb_text_overlay_gen.sv
// tb/tb_text_overlay_gen.sv - scoreboard bench for text_overlay_gen against a behavioural glyph/colour model
module tb_text_overlay_gen;

  localparam logic [9:0]  X0 = 10'd256;
  localparam logic [9:0]  Y0 = 10'd224;
  localparam int          CF = 60;
  localparam int          BF = 2;
  localparam logic [11:0] BG = 12'h124;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pixel_x = 10'd0;
  logic [9:0]  pixel_y = 10'd0;
  logic        video_on = 1'b0;
  logic        pixel_tick = 1'b0;
  logic [5:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        text_on;
  logic [11:0] rgb;

  logic [7:0] font [64];

  typedef struct {
    int         due;
    logic [5:0] addr;
  } addr_t;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        ton;
  } pix_t;

  addr_t addr_q [$];
  pix_t  pix_q [$];
  addr_t a_mon;
  pix_t  p_mon;

  int n_checks = 0;
  int n_pass = 0;
  int cycle_count = 0;
  int frames = 0;

  text_overlay_gen #(
    .TEXT_X0(X0),
    .TEXT_Y0(Y0),
    .COLOR_FRAMES(8'd60),
    .BLINK_FRAMES(8'd2),
    .BG_COLOR(BG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .video_on(video_on),
    .pixel_tick(pixel_tick),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .text_on(text_on),
    .rgb(rgb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data    <= font[rom_addr];
    cycle_count <= cycle_count + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cycle_count, act, exp);
  endtask

  function automatic logic [11:0] colour_of(input int f);
    case ((f / CF) % 3)
      0:       return 12'hF00;
      1:       return 12'h0F0;
      default: return 12'h00F;
    endcase
  endfunction

  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic v, input logic t, input logic r);
    int          dx;
    int          dy;
    int          idx;
    bit          inr;
    bit          lit;
    logic [7:0]  row;
    logic [5:0]  exp_addr;
    logic [11:0] exp_rgb;
    @(posedge clk);
    #1;
    reset = r;
    pixel_x = x;
    pixel_y = y;
    video_on = v;
    pixel_tick = t;
    dx  = int'(x) - int'(X0);
    dy  = int'(y) - int'(Y0);
    inr = (dx >= 0) && (dx < 24) && (dy >= 0) && (dy < 16);
    idx = (dx / 8 + 1) * 16 + dy;
    exp_addr = inr ? 6'(idx) : 6'd0;
    addr_q.push_back('{cycle_count, exp_addr});
    if (r) begin
      frames = 0;
      while (pix_q.size() > 0 && pix_q[$].due > cycle_count) void'(pix_q.pop_back());
      pix_q.push_back('{cycle_count + 1, 12'h000, 1'b0});
      pix_q.push_back('{cycle_count + 2, 12'h000, 1'b0});
    end else begin
      if (t && x == 10'd0 && y == 10'd0) frames++;
      lit = 1'b0;
      if (inr && v) begin
        row = font[idx];
        lit = row[7 - (dx % 8)];
      end
`ifdef TEXT_BLINK_EN
      if (((frames / BF) % 2) == 1) lit = 1'b0;
`endif
      exp_rgb = !v ? 12'h000 : (lit ? colour_of(frames) : BG);
      pix_q.push_back('{cycle_count + 2, exp_rgb, lit});
    end
  endtask

  always @(negedge clk) begin
    while (addr_q.size() > 0 && addr_q[0].due <= cycle_count) begin
      a_mon = addr_q.pop_front();
      check("rom_addr", 32'(rom_addr), 32'(a_mon.addr));
    end
    while (pix_q.size() > 0 && pix_q[0].due <= cycle_count) begin
      p_mon = pix_q.pop_front();
      check("rgb", 32'(rgb), 32'(p_mon.rgb));
      check("text_on", 32'(text_on), 32'(p_mon.ton));
    end
  end

  initial begin
    logic [7:0] s_rows [16];
    logic [7:0] a_rows [16];
    s_rows = '{8'h00, 8'h7E, 8'hC3, 8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E,
               8'h07, 8'h03, 8'hC3, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00};
    a_rows = '{8'h00, 8'h18, 8'h3C, 8'h66, 8'hC3, 8'hC3, 8'hFF, 8'hFF,
               8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) begin
      font[i]      = 8'h00;
      font[16 + i] = (i == 1 || i == 14) ? 8'hFF : ((i == 0 || i == 15) ? 8'h00 : 8'h18);
      font[32 + i] = s_rows[i];
      font[48 + i] = a_rows[i];
    end

    // Reset, then the directed pixels
    repeat (3) step(X0 + 10'd1, Y0 + 10'd1, 1'b1, 1'b0, 1'b1);
    repeat (2) step(X0, Y0 + 10'd1, 1'b1, 1'b0, 1'b0);
    step(X0 + 10'd8, Y0 + 10'd3, 1'b1, 1'b0, 1'b0);
    step(X0 + 10'd13, Y0 + 10'd3, 1'b1, 1'b0, 1'b0);
    step(X0 + 10'd24, Y0, 1'b1, 1'b0, 1'b0);
    step(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    step(X0, Y0 + 10'd1, 1'b0, 1'b0, 1'b0);
    step(X0 - 10'd1, Y0 + 10'd15, 1'b1, 1'b0, 1'b0);
    step(X0 + 10'd23, Y0 + 10'd16, 1'b1, 1'b0, 1'b0);

    // Blink/colour phase at a fixed lit pixel across the first frames
    for (int f = 0; f < 6; f++) begin
      repeat (3) step(X0, Y0 + 10'd1, 1'b1, 1'b0, 1'b0);
      step(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    end

    // Randomised pixels across enough frames to cycle all three colours
    for (int f = 0; f < 3 * CF + 8; f++) begin
      step(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++)
        step(X0 - 10'd3 + 10'($urandom % 30), Y0 - 10'd2 + 10'($urandom % 20),
             1'($urandom % 8 != 0), 1'($urandom % 2), 1'b0);
    end

    // One-clock reset in the middle of the string, also colliding with a frame pulse
    step(X0 + 10'd9, Y0 + 10'd5, 1'b1, 1'b0, 1'b0);
    step(X0 + 10'd9, Y0 + 10'd6, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++)
      step(X0 + 10'($urandom % 24), Y0 + 10'($urandom % 16), 1'b1, 1'b0, 1'b0);
    step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 4; k++)
        step(X0 + 10'($urandom % 24), Y0 + 10'($urandom % 16), 1'b1, 1'b0, 1'b0);
      step(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    end

    for (int i = 0; i < 10 && (pix_q.size() + addr_q.size()) > 0; i++) @(posedge clk);
    check("queue_drain", 32'(pix_q.size() + addr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
